// File: rtl/div_pkg.sv
// Shared types and sizing for the shift/subtract divider and its controller.
// Pure declarations: no logic, no latency, no backpressure.
package div_pkg;

   localparam int DEF_N = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CALC = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Step counter only has to reach N-1, so $clog2(N) bits suffice for N >= 2.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int DEF_KW = cnt_width(DEF_N);

endpackage

// File: rtl/divider_control.sv
// Divider sequencer: IDLE -> LOAD -> CALC x N -> DONE, or LOAD -> DONE on divide-by-zero.
// Moore strobes registered alongside the state; start is honoured only in IDLE, no stalls.
module divider_control
   import div_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   st,
   input  logic   dz_in,
   input  logic   last,
   output state_t state,
   output logic   idle,
   output logic   load,
   output logic   sh,
   output logic   sub,
   output logic   done
);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         idle  <= 1'b1;
         load  <= 1'b0;
         sh    <= 1'b0;
         sub   <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (st) begin
                  state <= S_LOAD;
                  idle  <= 1'b0;
                  load  <= 1'b1;
                  sh    <= 1'b0;
                  sub   <= 1'b0;
                  done  <= 1'b0;
               end else begin
                  state <= S_IDLE;
                  idle  <= 1'b1;
                  load  <= 1'b0;
                  sh    <= 1'b0;
                  sub   <= 1'b0;
                  done  <= 1'b0;
               end
            end
            S_LOAD: begin
               // A zero divisor skips the iteration entirely.
               if (dz_in) begin
                  state <= S_DONE;
                  idle  <= 1'b0;
                  load  <= 1'b0;
                  sh    <= 1'b0;
                  sub   <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state <= S_CALC;
                  idle  <= 1'b0;
                  load  <= 1'b0;
                  sh    <= 1'b1;
                  sub   <= 1'b1;
                  done  <= 1'b0;
               end
            end
            S_CALC: begin
               if (last) begin
                  state <= S_DONE;
                  idle  <= 1'b0;
                  load  <= 1'b0;
                  sh    <= 1'b0;
                  sub   <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state <= S_CALC;
                  idle  <= 1'b0;
                  load  <= 1'b0;
                  sh    <= 1'b1;
                  sub   <= 1'b1;
                  done  <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               idle  <= 1'b1;
               load  <= 1'b0;
               sh    <= 1'b0;
               sub   <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/shift_sub_divider.sv
// Unsigned restoring divider, one quotient bit per clock; done N+2 cycles after start (2 on /0).
// No backpressure: results hold in IDLE until the next LOAD, start is ignored while busy.
module shift_sub_divider
   import div_pkg::*;
#(
   parameter int N = DEF_N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         st,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         dz,
   output logic         idle,
   output logic         load,
   output logic         sh,
   output logic         sub,
   output logic         done
);

   localparam int KW = cnt_width(N);

   state_t        state;
   logic [N:0]    r;
   logic [N-1:0]  q;
   logic [N-1:0]  d;
   logic [KW-1:0] k;
   logic          dz_r;
   logic          divisor_zero;
   logic          last;

   logic [N:0]    r_sh;
   logic [N-1:0]  q_sh;
   logic [N+1:0]  diff;
   logic          borrow;

   assign divisor_zero = (divisor == '0);
   assign last         = (k == KW'(N - 1));

   divider_control u_ctrl (
      .clk   (clk),
      .rst   (rst),
      .st    (st),
      .dz_in (divisor_zero),
      .last  (last),
      .state (state),
      .idle  (idle),
      .load  (load),
      .sh    (sh),
      .sub   (sub),
      .done  (done)
   );

   // Trial subtract one bit wider than R so the top bit is the borrow.
   always_comb begin
      r_sh   = {r[N-1:0], q[N-1]};
      q_sh   = {q[N-2:0], 1'b0};
      diff   = {1'b0, r_sh} - {2'b00, d};
      borrow = diff[N+1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r    <= '0;
         q    <= '0;
         d    <= '0;
         k    <= '0;
         dz_r <= 1'b0;
      end else begin
         case (state)
            S_LOAD: begin
               d    <= divisor;
               k    <= '0;
               dz_r <= divisor_zero;
               // Divide-by-zero goes straight to DONE, so its result is written here.
               if (divisor_zero) begin
                  q <= '1;
                  r <= {1'b0, dividend};
               end else begin
                  q <= dividend;
                  r <= '0;
               end
            end
            S_CALC: begin
               k <= k + 1'b1;
               if (borrow) begin
                  r <= r_sh;
                  q <= q_sh;
               end else begin
                  r <= diff[N:0];
                  q <= {q_sh[N-1:1], 1'b1};
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign quotient  = q;
   assign remainder = r[N-1:0];
   assign dz        = dz_r;

endmodule
